// File: rtl/led_seq_pkg.sv
// Shared definitions for the LED pattern sequencer: animation modes,
// shift-direction encoding, the default power-up pattern and the
// prescaler period helper.
package led_seq_pkg;

   // Animation modes as driven on the mode input.
   typedef enum logic [1:0] {
      MODE_ROTATE = 2'b00,
      MODE_BOUNCE = 2'b01,
      MODE_BLINK  = 2'b10,
      MODE_HOLD   = 2'b11
   } mode_e;

   // Shift direction: left moves bits toward the MSB, right toward the LSB.
   localparam logic DIR_LEFT  = 1'b0;
   localparam logic DIR_RIGHT = 1'b1;

   // Power-up pattern, pre-inverted so active-low boards show 001100110010.
   localparam logic [11:0] DEFAULT_RESET_PAT = ~12'b0011_0011_0010;

   // Clocks per animation step for a given speed select.
   function automatic int unsigned step_period(int unsigned base_div,
                                               int unsigned speed);
      return base_div << speed;
   endfunction

endpackage

// File: rtl/led_seq_ctrl_tick_gen.sv
// Step-rate prescaler. Counts clocks while enabled and flags the last
// clock of each period. The >= compare lets a mid-count speed reduction
// tick on the very next cycle instead of wrapping the counter.
module led_tick_gen
   import led_seq_pkg::*;
#(
   parameter int unsigned CNT_W    = 28,
   parameter int unsigned BASE_DIV = 2**24,
   parameter int unsigned SPEED_W  = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               en,
   input  logic               clr,
   input  logic [SPEED_W-1:0] speed,
   output logic               tick
);

   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] limit;

   // Terminal count for the currently selected speed (period minus one).
   assign limit = CNT_W'(step_period(BASE_DIV, 32'(speed)) - 32'd1);

   // Tick is a combinational flag; the owner decides whether to act on it.
   assign tick = en && (cnt >= limit);

   // Prescaler counter: clear wins, otherwise count or wrap while enabled.
   // NOTE: sequential state is assigned with <= so every flop samples the
   // pre-edge values of its inputs regardless of statement order.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= tick ? '0 : cnt + CNT_W'(1);
      end
   end

endmodule

// File: rtl/led_seq_ctrl.sv
// LED pattern sequencer. Drives a WIDTH-bit LED bank with rotate, bounce,
// blink or hold animations advanced by a programmable prescaler tick.
// A one-cycle load strobe replaces the pattern and restarts the period.
module led_seq_ctrl
   import led_seq_pkg::*;
#(
   parameter int unsigned      WIDTH     = 12,
   parameter int unsigned      CNT_W     = 28,
   parameter int unsigned      BASE_DIV  = 2**24,
   parameter int unsigned      SPEED_W   = 2,
   parameter logic [WIDTH-1:0] RESET_PAT = WIDTH'(DEFAULT_RESET_PAT)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               en,
   input  logic [1:0]         mode,
   input  logic               direction,
   input  logic [SPEED_W-1:0] speed,
   input  logic               load,
   input  logic [WIDTH-1:0]   load_pat,
   output logic [WIDTH-1:0]   led,
   output logic               step,
   output logic               dir_state
);

   mode_e            mode_cur;
   mode_e            mode_q;
   logic             tick;
   logic             enter_bounce;
   logic             dir_eff;
   logic [WIDTH-1:0] rot_left;
   logic [WIDTH-1:0] rot_right;
   logic [WIDTH-1:0] bounce_led;
   logic             bounce_dir;
   logic [WIDTH-1:0] led_next;
   logic             dir_next;
   logic             step_next;

   assign mode_cur = mode_e'(mode);

   // Prescaler; a load restarts the step period from zero.
   led_tick_gen #(
      .CNT_W    (CNT_W),
      .BASE_DIV (BASE_DIV),
      .SPEED_W  (SPEED_W)
   ) u_tick_gen (
      .clk   (clk),
      .rst   (rst),
      .en    (en),
      .clr   (load),
      .speed (speed),
      .tick  (tick)
   );

   // Entering bounce re-seeds the bounce direction from the live input;
   // the same-cycle value is used so a coincident tick already honours it.
   assign enter_bounce = (mode_cur == MODE_BOUNCE) && (mode_q != MODE_BOUNCE);
   assign dir_eff      = enter_bounce ? direction : dir_state;

   // Circular shifts for rotate mode.
   assign rot_left  = {led[WIDTH-2:0], led[WIDTH-1]};
   assign rot_right = {led[0], led[WIDTH-1:1]};

   // Bounce step: zero-fill shift, reversing when a set bit would fall off.
   // NOTE: every output of a combinational block gets a default first so
   // no path leaves it unassigned and no latch is inferred.
   always_comb begin
      bounce_led = led;
      bounce_dir = dir_eff;
      if (led[WIDTH-1] && led[0]) begin
         // Both ends lit: nowhere to go, so only the direction flips.
         bounce_dir = ~dir_eff;
      end else if (dir_eff == DIR_LEFT) begin
         if (led[WIDTH-1]) begin
            bounce_dir = DIR_RIGHT;
            bounce_led = led >> 1;
         end else begin
            bounce_led = led << 1;
         end
      end else begin
         if (led[0]) begin
            bounce_dir = DIR_LEFT;
            bounce_led = led << 1;
         end else begin
            bounce_led = led >> 1;
         end
      end
   end

   // Next pattern, bounce direction and step pulse; load beats tick.
   always_comb begin
      led_next  = led;
      dir_next  = dir_state;
      step_next = 1'b0;
      if (load) begin
         led_next = load_pat;
         dir_next = direction;
      end else if (en) begin
         dir_next = dir_eff;
         if (tick) begin
            unique case (mode_cur)
               MODE_ROTATE: begin
                  led_next  = (direction == DIR_LEFT) ? rot_left : rot_right;
                  step_next = 1'b1;
               end
               MODE_BOUNCE: begin
                  led_next  = bounce_led;
                  dir_next  = bounce_dir;
                  step_next = 1'b1;
               end
               MODE_BLINK: begin
                  led_next  = ~led;
                  step_next = 1'b1;
               end
               MODE_HOLD: begin
                  led_next  = led;
                  step_next = 1'b0;
               end
            endcase
         end
      end
   end

   // Output and mode-history registers; reset drops any pending step.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         led       <= RESET_PAT;
         step      <= 1'b0;
         dir_state <= DIR_LEFT;
         mode_q    <= MODE_ROTATE;
      end else begin
         led       <= led_next;
         step      <= step_next;
         dir_state <= dir_next;
         mode_q    <= mode_cur;
      end
   end

endmodule

// File: tb/tb_led_seq_ctrl.sv
// Self-checking bench for led_seq_ctrl: a hand-derived vector table for
// the deterministic scenarios, a short reset sequence, then randomized
// stimulus compared against a cycle-level behavioural model.
module tb_led_seq_ctrl;
   import led_seq_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        en = 1'b1;
   logic [1:0]  mode = 2'b00;
   logic        direction = 1'b0;
   logic [1:0]  speed = 2'b00;
   logic        load = 1'b0;
   logic [11:0] load_pat = 12'h000;
   logic [11:0] led;
   logic        step;
   logic        dir_state;

   int checks = 0;
   int failures = 0;

   led_seq_ctrl #(
      .WIDTH    (12),
      .CNT_W    (8),
      .BASE_DIV (4),
      .SPEED_W  (2)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .mode      (mode),
      .direction (direction),
      .speed     (speed),
      .load      (load),
      .load_pat  (load_pat),
      .led       (led),
      .step      (step),
      .dir_state (dir_state)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [11:0] act, input logic [11:0] want);
      checks++;
      if (act !== want) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, want);
      end
   endtask

   // ---------------- behavioural reference model ----------------
   bit [11:0] m_led = 12'hCCD;
   int        m_cnt = 0;
   bit        m_dir = 1'b0;
   bit        m_step = 1'b0;
   int        m_prev_mode = 0;

   function automatic void model_step();
      int v;
      int period;
      bit tick_now;
      bit entering;
      bit msb;
      bit lsb;
      if (!rst) begin
         m_led = 12'hCCD; m_cnt = 0; m_dir = 1'b0; m_step = 1'b0; m_prev_mode = 0;
         return;
      end
      period   = 4 << speed;
      tick_now = en && (m_cnt >= period - 1);
      entering = (int'(mode) == 1) && (m_prev_mode != 1);
      m_prev_mode = int'(mode);
      m_step = 1'b0;
      if (load) begin
         m_led = load_pat; m_cnt = 0; m_dir = direction;
         return;
      end
      if (!en) return;
      if (entering) m_dir = direction;
      m_cnt = tick_now ? 0 : m_cnt + 1;
      if (!tick_now) return;
      v = int'(m_led);
      case (int'(mode))
         0: begin
            if (direction == 1'b0) v = (v * 2) % 4096 + v / 2048;
            else                   v = v / 2 + (v % 2) * 2048;
            m_step = 1'b1;
         end
         1: begin
            msb = (v >= 2048);
            lsb = (v % 2 == 1);
            if (msb && lsb) begin
               m_dir = ~m_dir;
            end else begin
               if ((m_dir == 1'b0 && msb) || (m_dir == 1'b1 && lsb)) m_dir = ~m_dir;
               if (m_dir == 1'b0) v = (v * 2) % 4096;
               else               v = v / 2;
            end
            m_step = 1'b1;
         end
         2: begin
            v = 4095 - v;
            m_step = 1'b1;
         end
         default: m_step = 1'b0;
      endcase
      m_led = 12'(v);
   endfunction

   // One clock: advance the model on the edge, then settle past the edge.
   task automatic tick_clk();
      @(posedge clk);
      model_step();
      #1;
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic        en;
      logic [1:0]  mode;
      logic        direction;
      logic [1:0]  speed;
      logic        load;
      logic [11:0] load_pat;
      int          cycles;
      logic [11:0] exp_led;
      logic        exp_step;
      logic        exp_dir;
   } vec_t;

   vec_t vecs[$];

   function automatic void add(input logic e, input logic [1:0] md, input logic d,
                               input logic [1:0] sp, input logic ld, input logic [11:0] pat,
                               input int cyc, input logic [11:0] xl, input logic xs,
                               input logic xd);
      vec_t v;
      v.en = e; v.mode = md; v.direction = d; v.speed = sp; v.load = ld;
      v.load_pat = pat; v.cycles = cyc; v.exp_led = xl; v.exp_step = xs; v.exp_dir = xd;
      vecs.push_back(v);
   endfunction

   function automatic void build_table();
      // Rotate left at speed 0, wrap, then live direction change.
      add(1, MODE_ROTATE, 0, 0, 1, 12'h001, 1, 12'h001, 0, 0);
      for (int k = 1; k <= 3; k++) add(1, MODE_ROTATE, 0, 0, 0, 12'h000, 4, 12'(1 << k), 1, 0);
      add(1, MODE_ROTATE, 0, 0, 1, 12'h800, 1, 12'h800, 0, 0);
      add(1, MODE_ROTATE, 0, 0, 0, 12'h000, 4, 12'h001, 1, 0);
      add(1, MODE_ROTATE, 1, 0, 0, 12'h000, 4, 12'h800, 1, 0);
      add(1, MODE_ROTATE, 1, 0, 0, 12'h000, 4, 12'h400, 1, 0);
      // Speed 2 gives 16-clock steps; dropping to 0 at cnt=10 ticks at once.
      add(1, MODE_ROTATE, 0, 2, 1, 12'h001, 1, 12'h001, 0, 0);
      add(1, MODE_ROTATE, 0, 2, 0, 12'h000, 15, 12'h001, 0, 0);
      add(1, MODE_ROTATE, 0, 2, 0, 12'h000, 1, 12'h002, 1, 0);
      add(1, MODE_ROTATE, 0, 2, 0, 12'h000, 16, 12'h004, 1, 0);
      add(1, MODE_ROTATE, 0, 2, 0, 12'h000, 10, 12'h004, 0, 0);
      add(1, MODE_ROTATE, 0, 0, 0, 12'h000, 1, 12'h008, 1, 0);
      add(1, MODE_ROTATE, 0, 0, 0, 12'h000, 4, 12'h010, 1, 0);
      // Bounce: walk to the MSB, reverse, walk to the LSB, reverse again.
      // The direction input is held at 1 during the walk and must be ignored.
      add(1, MODE_BOUNCE, 0, 0, 1, 12'h001, 1, 12'h001, 0, 0);
      for (int k = 1; k <= 11; k++) add(1, MODE_BOUNCE, 1, 0, 0, 12'h000, 4, 12'(1 << k), 1, 0);
      add(1, MODE_BOUNCE, 1, 0, 0, 12'h000, 4, 12'h400, 1, 1);
      for (int k = 9; k >= 0; k--) add(1, MODE_BOUNCE, 1, 0, 0, 12'h000, 4, 12'(1 << k), 1, 1);
      add(1, MODE_BOUNCE, 1, 0, 0, 12'h000, 4, 12'h002, 1, 0);
      // Both ends lit: pattern holds, direction toggles, step still pulses.
      add(1, MODE_BOUNCE, 0, 0, 1, 12'h801, 1, 12'h801, 0, 0);
      add(1, MODE_BOUNCE, 0, 0, 0, 12'h000, 4, 12'h801, 1, 1);
      add(1, MODE_BOUNCE, 0, 0, 0, 12'h000, 4, 12'h801, 1, 0);
      // All-zero bounce pattern stays zero but still steps.
      add(1, MODE_BOUNCE, 0, 0, 1, 12'h000, 1, 12'h000, 0, 0);
      add(1, MODE_BOUNCE, 0, 0, 0, 12'h000, 4, 12'h000, 1, 0);
      // Load in the tick cycle wins; period restarts; blink alternates.
      add(1, MODE_BLINK, 0, 0, 1, 12'h001, 1, 12'h001, 0, 0);
      add(1, MODE_BLINK, 0, 0, 0, 12'h000, 3, 12'h001, 0, 0);
      add(1, MODE_BLINK, 0, 0, 1, 12'h0F0, 1, 12'h0F0, 0, 0);
      add(1, MODE_BLINK, 0, 0, 0, 12'h000, 3, 12'h0F0, 0, 0);
      add(1, MODE_BLINK, 0, 0, 0, 12'h000, 1, 12'hF0F, 1, 0);
      add(1, MODE_BLINK, 0, 0, 0, 12'h000, 4, 12'h0F0, 1, 0);
      add(1, MODE_BLINK, 0, 0, 0, 12'h000, 4, 12'hF0F, 1, 0);
      // en=0 freezes counter and pattern: 2 + (20 frozen) + 2 clocks to a step.
      add(1, MODE_BLINK, 0, 0, 0, 12'h000, 2, 12'hF0F, 0, 0);
      add(0, MODE_BLINK, 0, 0, 0, 12'h000, 20, 12'hF0F, 0, 0);
      add(1, MODE_BLINK, 0, 0, 0, 12'h000, 1, 12'hF0F, 0, 0);
      add(1, MODE_BLINK, 0, 0, 0, 12'h000, 1, 12'h0F0, 1, 0);
      // Hold: prescaler runs but nothing changes and no step.
      add(1, MODE_HOLD, 0, 0, 0, 12'h000, 4, 12'h0F0, 0, 0);
      add(1, MODE_HOLD, 0, 0, 0, 12'h000, 4, 12'h0F0, 0, 0);
      // Load acts while disabled and copies direction into dir_state.
      add(0, MODE_HOLD, 1, 0, 1, 12'h0A5, 1, 12'h0A5, 0, 1);
   endfunction

   initial begin
      build_table();

      // Asynchronous reset takes effect before any clock edge.
      #2 rst = 1'b0;
      #1;
      check("reset_led", led, 12'hCCD);
      check("reset_step", 12'(step), 12'h0);
      check("reset_dir", 12'(dir_state), 12'h0);
      tick_clk();
      tick_clk();
      rst = 1'b1;

      foreach (vecs[i]) begin
         en        = vecs[i].en;
         mode      = vecs[i].mode;
         direction = vecs[i].direction;
         speed     = vecs[i].speed;
         load_pat  = vecs[i].load_pat;
         for (int c = 0; c < vecs[i].cycles; c++) begin
            load = vecs[i].load && (c == 0);
            tick_clk();
         end
         load = 1'b0;
         check($sformatf("vec%0d_led", i), led, vecs[i].exp_led);
         check($sformatf("vec%0d_step", i), 12'(step), 12'(vecs[i].exp_step));
         check($sformatf("vec%0d_dir", i), 12'(dir_state), 12'(vecs[i].exp_dir));
      end

      // Reset asserted mid-operation while a step pulse is showing.
      en = 1'b1; mode = MODE_BOUNCE; direction = 1'b1; speed = 2'd0;
      load = 1'b1; load_pat = 12'h400;
      tick_clk();
      load = 1'b0;
      repeat (4) tick_clk();
      check("pre_reset_led", led, 12'h200);
      check("pre_reset_step", 12'(step), 12'h1);
      check("pre_reset_dir", 12'(dir_state), 12'h1);
      #2 rst = 1'b0;
      #1;
      check("midrst_led", led, 12'hCCD);
      check("midrst_step", 12'(step), 12'h0);
      check("midrst_dir", 12'(dir_state), 12'h0);
      tick_clk();
      check("inrst_led", led, 12'hCCD);
      rst = 1'b1;
      // First clock after reset sees a fresh entry into bounce.
      tick_clk();
      check("post_rst_led", led, 12'hCCD);
      check("post_rst_step", 12'(step), 12'h0);
      check("post_rst_enter_dir", 12'(dir_state), 12'h1);

      // Randomized stimulus against the behavioural model.
      for (int n = 0; n < 3000; n++) begin
         load     = ($urandom_range(0, 19) == 0);
         load_pat = 12'($urandom);
         en       = ($urandom_range(0, 9) != 0);
         if ($urandom_range(0, 24) == 0) mode = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 9) == 0) direction = ~direction;
         if ($urandom_range(0, 39) == 0) speed = 2'($urandom_range(0, 1));
         tick_clk();
         check("rnd_led", led, m_led);
         check("rnd_step", 12'(step), 12'(m_step));
         check("rnd_dir", 12'(dir_state), 12'(m_dir));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
